// File: rtl/mma_pkg.sv
// mma_pkg: requester indices and arbiter state encoding shared by the MMA ICB arbitration logic.
package mma_pkg;
   localparam int REQ_IA     = 0;
   localparam int REQ_WEIGHT = 1;
   localparam int REQ_BIAS   = 2;
   localparam int REQ_QUANT  = 3;
   localparam int REQ_OA     = 4;
   typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_e;
endpackage

// File: rtl/icb_access_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting at rr_ptr, overridden by the urgent requester.
module rr_pick #(
   parameter int NUM_REQ    = 5,
   parameter int SEL_WIDTH  = 3,
   parameter int URGENT_IDX = 4
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [SEL_WIDTH-1:0] rr_ptr,
   input  logic                 urgent,
   output logic                 found,
   output logic [SEL_WIDTH-1:0] win
);
   logic [SEL_WIDTH-1:0] idx;
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      // scan from the farthest offset down so the nearest set request is the last one kept
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = SEL_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
         if (req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      if (urgent && req[URGENT_IDX]) begin
         found = 1'b1;
         win   = SEL_WIDTH'(URGENT_IDX);
      end
   end
endmodule

// File: rtl/icb_access_arbiter.sv
// icb_access_arbiter: grants the shared ICB port to one MMA loader/writer at a time,
// holding the grant until done and inserting a one-cycle drain gap between owners.
module icb_access_arbiter
   import mma_pkg::*;
#(
   parameter int NUM_REQ    = 5,
   parameter int SEL_WIDTH  = 3,
   parameter int URGENT_IDX = REQ_OA,
   parameter int TIMEOUT    = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   done,
   input  logic                 urgent,
   output logic [NUM_REQ-1:0]   grant,
   output logic [SEL_WIDTH-1:0] icb_sel,
   output logic                 busy,
   output logic                 timeout_err,
   input  logic                 clr_err
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   arb_state_e           state, state_d;
   logic [SEL_WIDTH-1:0] rr_ptr, win;
   logic [CNT_W-1:0]     hold_cnt;
   logic                 found, arb, owner_done;
   rr_pick #(.NUM_REQ(NUM_REQ), .SEL_WIDTH(SEL_WIDTH), .URGENT_IDX(URGENT_IDX)) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .urgent (urgent),
      .found  (found),
      .win    (win)
   );
   always_comb begin
      owner_done = done[icb_sel];
      arb        = enable && found && state != GRANT;
      state_d    = state == GRANT ? (owner_done ? GAP : GRANT) : (arb ? GRANT : IDLE);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end
   assign busy = state != IDLE;
   // the counter parks at TIMEOUT so the error is raised once per grant and clr_err can take effect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant       <= '0;
         icb_sel     <= '0;
         rr_ptr      <= '0;
         hold_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (arb) begin
            grant   <= NUM_REQ'(1) << win;
            icb_sel <= win;
            rr_ptr  <= win == SEL_WIDTH'(NUM_REQ - 1) ? '0 : win + 1'b1;
         end else if (state == GRANT && owner_done) begin
            grant <= '0;
         end
         hold_cnt    <= arb ? '0 : (state == GRANT && hold_cnt != CNT_W'(TIMEOUT)) ? hold_cnt + 1'b1 : hold_cnt;
         timeout_err <= (state == GRANT && hold_cnt == CNT_W'(TIMEOUT - 1)) ? 1'b1 : clr_err ? 1'b0 : timeout_err;
      end
   end
endmodule

// File: tb/tb_icb_access_arbiter.sv
// tb_icb_access_arbiter: scenario tasks with a queue of expected winners checked as grants appear.
module tb_icb_access_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b1;
   logic [4:0] req = '0;
   logic [4:0] done = '0;
   logic       urgent = 1'b0;
   logic       clr_err = 1'b0;
   logic [4:0] grant;
   logic [2:0] icb_sel;
   logic       busy;
   logic       timeout_err;
   int         checks = 0;
   int         errors = 0;
   int         exp_q[$];
   icb_access_arbiter #(.NUM_REQ(5), .SEL_WIDTH(3), .URGENT_IDX(4), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .req         (req),
      .done        (done),
      .urgent      (urgent),
      .grant       (grant),
      .icb_sel     (icb_sel),
      .busy        (busy),
      .timeout_err (timeout_err),
      .clr_err     (clr_err)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   always @(negedge clk) begin
      checks++;
      if (!$onehot0(grant) || (grant != 0 && !grant[icb_sel])) begin
         errors++;
         $display("FAIL invariant: grant=%b icb_sel=%0d", grant, icb_sel);
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst_n = 1'b0; req = '0; done = '0; urgent = 1'b0; enable = 1'b1; clr_err = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask
   task automatic test_reset();
      do_reset();
      checks++;
      if ({grant, icb_sel, busy, timeout_err} !== 10'b0) begin
         errors++;
         $display("FAIL reset: grant=%b sel=%0d busy=%b err=%b, want all zero", grant, icb_sel, busy, timeout_err);
      end
   endtask
   task automatic test_single();
      int e;
      do_reset();
      req = 5'b00010;
      exp_q.push_back(1);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (grant !== 5'b00001 << e || icb_sel !== 3'(e)) begin
         errors++;
         $display("FAIL single_grant: grant=%b sel=%0d, want %b sel=%0d", grant, icb_sel, 5'b00001 << e, e);
      end
      repeat (4) tick();
      done = 5'b00010; req = '0;
      tick();
      done = '0;
      checks++;
      if (grant !== 5'b0 || busy !== 1'b1 || icb_sel !== 3'd1) begin
         errors++;
         $display("FAIL single_gap: grant=%b busy=%b sel=%0d, want 00000 1 1", grant, busy, icb_sel);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || grant !== 5'b0) begin
         errors++;
         $display("FAIL single_idle: busy=%b grant=%b, want 0 00000", busy, grant);
      end
   endtask
   task automatic test_round_robin();
      int e;
      do_reset();
      req = 5'b11111;
      foreach (exp_q[i]) exp_q.delete(i);
      for (int k = 0; k < 6; k++) exp_q.push_back(k % 5);
      tick();
      for (int k = 0; k < 6; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (grant !== 5'b00001 << e || icb_sel !== 3'(e)) begin
            errors++;
            $display("FAIL rr_order[%0d]: grant=%b sel=%0d, want %b sel=%0d", k, grant, icb_sel, 5'b00001 << e, e);
         end
         repeat (3) tick();
         done = 5'b00001 << e;
         if (k == 5) req = '0;
         tick();
         done = '0;
         checks++;
         if (grant !== 5'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rr_gap[%0d]: grant=%b busy=%b, want 00000 1", k, grant, busy);
         end
         tick();
      end
   endtask
   task automatic test_urgent();
      int e;
      for (int u = 1; u >= 0; u--) begin
         do_reset();
         req = 5'b00001;
         tick();
         req = '0; done = 5'b00001;
         tick();
         done = '0;
         req = 5'b10110; urgent = 1'(u);
         exp_q.push_back(u ? 4 : 1);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (grant !== 5'b00001 << e || icb_sel !== 3'(e)) begin
            errors++;
            $display("FAIL urgent_%0d: grant=%b sel=%0d, want %b sel=%0d", u, grant, icb_sel, 5'b00001 << e, e);
         end
      end
   endtask
   task automatic test_ignored();
      do_reset();
      req = 5'b00001;
      tick();
      done = 5'b00100;
      tick();
      done = '0;
      checks++;
      if (grant !== 5'b00001) begin
         errors++;
         $display("FAIL foreign_done: grant=%b, want 00001", grant);
      end
      req = '0;
      repeat (3) tick();
      checks++;
      if (grant !== 5'b00001 || busy !== 1'b1) begin
         errors++;
         $display("FAIL req_drop: grant=%b busy=%b, want 00001 1", grant, busy);
      end
      done = 5'b00001;
      tick();
      done = '0;
      checks++;
      if (grant !== 5'b0) begin
         errors++;
         $display("FAIL owner_done: grant=%b, want 00000", grant);
      end
   endtask
   task automatic test_timeout();
      do_reset();
      req = 5'b00100;
      tick();
      repeat (15) tick();
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: err=%b, want 0", timeout_err);
      end
      clr_err = 1'b1;
      tick();
      checks++;
      if (timeout_err !== 1'b1 || grant !== 5'b00100) begin
         errors++;
         $display("FAIL timeout_set: err=%b grant=%b, want 1 00100", timeout_err, grant);
      end
      tick();
      clr_err = 1'b0;
      checks++;
      if (timeout_err !== 1'b0 || grant !== 5'b00100) begin
         errors++;
         $display("FAIL timeout_clr: err=%b grant=%b, want 0 00100", timeout_err, grant);
      end
   endtask
   task automatic test_enable_reset();
      int e;
      do_reset();
      enable = 1'b0; req = 5'b01000;
      repeat (2) tick();
      checks++;
      if (grant !== 5'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL enable_low: grant=%b busy=%b, want 00000 0", grant, busy);
      end
      enable = 1'b1;
      exp_q.push_back(3);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (grant !== 5'b00001 << e || icb_sel !== 3'(e)) begin
         errors++;
         $display("FAIL enable_high: grant=%b sel=%0d, want %b sel=%0d", grant, icb_sel, 5'b00001 << e, e);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (grant !== 5'b0 || icb_sel !== 3'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: grant=%b sel=%0d busy=%b, want 00000 0 0", grant, icb_sel, busy);
      end
      tick();
      rst_n = 1'b1;
   endtask
   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_urgent();
      test_ignored();
      test_timeout();
      test_enable_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
